// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default reset vector, canonical NOP word and a word-alignment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'h0000_0000;

    // addi x0, x0, 0 -- what the decoder treats as "no operation"
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Single-word instruction memory read port with request/acknowledge handshake.
//   fetchAddress  : read address, word aligned, stable while fetchRequest=1
//   fetchRequest  : read request, held until acknowledged
//   fetchAck      : memory completes the read this cycle
//   fetchData     : read data, valid when fetchAck=1
//   fetchError    : bus error, qualified by fetchAck
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instruction_fetch_if;

    logic [31:0] fetchAddress;
    logic        fetchRequest;
    logic        fetchAck;
    logic [31:0] fetchData;
    logic        fetchError;

    modport master (
        output fetchAddress,
        output fetchRequest,
        input  fetchAck,
        input  fetchData,
        input  fetchError
    );

    modport slave (
        input  fetchAddress,
        input  fetchRequest,
        output fetchAck,
        output fetchData,
        output fetchError
    );

endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage in front of the instruction decoder. Owns the program counter,
// reads one word at a time from instruction memory and holds it until the
// downstream stage consumes it. Handles redirects, including ones that land
// while a read is still outstanding.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   enable              : run enable; no new read is started while low
//   jumpEnable          : single-cycle redirect strobe
//   jumpAddress         : redirect target
//   instructionReady    : downstream consumes the held word this cycle
//   mem                 : instruction memory read port (master side)
//   currentInstruction  : held instruction word
//   isNOP               : 1 when no valid instruction is presented
//   programCounter      : address of currentInstruction
//   instructionFault    : held word came back with a bus error
//   addressMisaligned   : last redirect target was not word aligned
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = DEFAULT_RESET_ADDRESS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       jumpEnable,
    input  logic [31:0]                jumpAddress,
    input  logic                       instructionReady,
    instruction_fetch_if.master        mem,
    output logic [31:0]                currentInstruction,
    output logic                       isNOP,
    output logic [31:0]                programCounter,
    output logic                       instructionFault,
    output logic                       addressMisaligned
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         fault_q, fault_d;
    logic         misaligned_q, misaligned_d;

    logic         req_active;
    logic         req_pending;
    logic         jump_aligned;

    assign req_active   = (state_q == FETCH) || (state_q == FLUSH);
    // A read stays outstanding into the next cycle unless it is acked now.
    assign req_pending  = req_active && !mem.fetchAck;
    assign jump_aligned = is_word_aligned(jumpAddress[1:0]);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        fault_d      = fault_q;
        misaligned_d = misaligned_q;

        if (jumpEnable) begin
            // Redirect beats ack and consume; any held word is dropped.
            if (jump_aligned) begin
                pc_d         = jumpAddress;
                misaligned_d = 1'b0;
            end else begin
                misaligned_d = 1'b1;
            end

            // An outstanding read must still be drained, its data thrown away.
            // A redirect that coincides with the ack finds the bus free again.
            if (req_pending) begin
                state_d = FLUSH;
            end else if (enable && jump_aligned) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // A misaligned redirect parks the stage until the next
                    // aligned redirect or reset.
                    if (enable && !misaligned_q) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (mem.fetchAck) begin
                        instr_d    = mem.fetchData;
                        instr_pc_d = pc_q;
                        fault_d    = mem.fetchError;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (instructionReady) begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = enable ? FETCH : IDLE;
                    end
                end
                FLUSH: begin
                    if (mem.fetchAck) begin
                        state_d = (enable && !misaligned_q) ? FETCH : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The bus address is frozen for the life of a request, even if the
        // pc is redirected underneath it; otherwise it follows the next pc.
        fetch_addr_d = req_pending ? fetch_addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_ADDRESS;
            fetch_addr_q <= RESET_ADDRESS;
            instr_q      <= 32'h0000_0000;
            instr_pc_q   <= RESET_ADDRESS;
            fault_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            fault_q      <= fault_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign mem.fetchRequest   = req_active;
    assign mem.fetchAddress   = fetch_addr_q;
    assign isNOP              = (state_q != HOLD);
    assign currentInstruction = instr_q;
    assign programCounter     = instr_pc_q;
    assign instructionFault   = fault_q;
    assign addressMisaligned  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch: a directed vector table, a
// hand-written reset-during-fetch sequence, then randomized traffic checked
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        jumpEnable;
    logic [31:0] jumpAddress;
    logic        instructionReady;
    logic [31:0] currentInstruction;
    logic        isNOP;
    logic [31:0] programCounter;
    logic        instructionFault;
    logic        addressMisaligned;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_if mem_if ();

    instruction_fetch #(
        .RESET_ADDRESS(32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .jumpEnable         (jumpEnable),
        .jumpAddress        (jumpAddress),
        .instructionReady   (instructionReady),
        .mem                (mem_if),
        .currentInstruction (currentInstruction),
        .isNOP              (isNOP),
        .programCounter     (programCounter),
        .instructionFault   (instructionFault),
        .addressMisaligned  (addressMisaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic jmp, input logic [31:0] ja,
                         input logic rdy, input logic ack, input logic [31:0] d, input logic e);
        enable            = en;
        jumpEnable        = jmp;
        jumpAddress       = ja;
        instructionReady  = rdy;
        mem_if.fetchAck   = ack;
        mem_if.fetchData  = d;
        mem_if.fetchError = e;
    endtask

    // Compare all visible outputs; address only matters while requesting,
    // the instruction fields only while one is presented.
    task automatic check_outputs(input string tag, input logic x_req, input logic [31:0] x_addr,
                                 input logic x_nop, input logic [31:0] x_instr,
                                 input logic [31:0] x_pc, input logic x_fault, input logic x_mis);
        check({tag, ".fetchRequest"}, 32'(mem_if.fetchRequest), 32'(x_req));
        if (x_req) check({tag, ".fetchAddress"}, mem_if.fetchAddress, x_addr);
        check({tag, ".isNOP"}, 32'(isNOP), 32'(x_nop));
        if (!x_nop) begin
            check({tag, ".currentInstruction"}, currentInstruction, x_instr);
            check({tag, ".programCounter"}, programCounter, x_pc);
            check({tag, ".instructionFault"}, 32'(instructionFault), 32'(x_fault));
        end
        check({tag, ".addressMisaligned"}, 32'(addressMisaligned), 32'(x_mis));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic        jmp;
        logic [31:0] ja;
        logic        rdy;
        logic        ack;
        logic [31:0] data;
        logic        err;
        logic        x_req;
        logic [31:0] x_addr;
        logic        x_nop;
        logic [31:0] x_instr;
        logic [31:0] x_pc;
        logic        x_fault;
        logic        x_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic jmp, input logic [31:0] ja, input logic rdy,
                       input logic ack, input logic [31:0] data, input logic err,
                       input logic x_req, input logic [31:0] x_addr, input logic x_nop,
                       input logic [31:0] x_instr, input logic [31:0] x_pc,
                       input logic x_fault, input logic x_mis);
        vec_t v;
        v.en = en; v.jmp = jmp; v.ja = ja; v.rdy = rdy; v.ack = ack; v.data = data; v.err = err;
        v.x_req = x_req; v.x_addr = x_addr; v.x_nop = x_nop; v.x_instr = x_instr;
        v.x_pc = x_pc; v.x_fault = x_fault; v.x_mis = x_mis;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Transaction view: is a read outstanding, will its data be dropped,
    // is a word held for decode, is fetching halted by a bad redirect.
    bit          m_busy, m_discard, m_have, m_halted;
    logic [31:0] m_pc, m_req_addr, m_instr, m_ipc;
    bit          m_fault;

    task automatic model_reset();
        m_busy = 0; m_discard = 0; m_have = 0; m_halted = 0;
        m_pc = 32'h0; m_req_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_fault = 0;
    endtask

    task automatic model_step(input logic en, input logic jmp, input logic [31:0] ja,
                              input logic rdy, input logic ack, input logic [31:0] d, input logic e);
        bit still_out;
        bit nb;
        still_out = m_busy && !ack;
        nb = 0;
        if (jmp) begin
            if (ja[1:0] == 2'b00) begin
                m_pc = ja;
                m_halted = 0;
            end else begin
                m_halted = 1;
            end
            m_have = 0;
            if (still_out) begin
                nb = 1;
                m_discard = 1;
            end else begin
                nb = en && !m_halted;
                m_discard = 0;
            end
        end else if (m_busy) begin
            if (!ack) begin
                nb = 1;
            end else if (m_discard) begin
                nb = en && !m_halted;
                m_discard = 0;
            end else begin
                m_have = 1; m_instr = d; m_ipc = m_pc; m_fault = e;
                nb = 0;
            end
        end else if (m_have) begin
            if (rdy) begin
                m_pc = m_pc + 32'd4;
                m_have = 0;
                nb = en;
            end
        end else begin
            nb = en && !m_halted;
        end
        if (nb && !still_out) m_req_addr = m_pc;
        m_busy = nb;
    endtask

    initial begin
        logic        r_en, r_jmp, r_rdy, r_ack, r_err;
        logic [31:0] r_ja, r_d;

        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset", 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        check("reset.currentInstruction", currentInstruction, 32'h0);
        check("reset.programCounter", programCounter, 32'h0);
        check("reset.instructionFault", 32'(instructionFault), 32'h0);

        //  en jmp ja            rdy ack data           err | req addr          nop instr          pc            flt mis
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'h0050_0093,  0,   0, 32'h0,          0, 32'h0050_0093,  32'h0,         0, 0);
        for (int i = 0; i < 5; i++)
            add(1, 0, 32'h0,      0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0050_0093,  32'h0,         0, 0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h4,          1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'h0000_0113,  0,   0, 32'h0,          0, 32'h0000_0113,  32'h4,         0, 0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          32'h0,         0, 0);
        add(1, 1, 32'h100,        0, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0,   1, 32'h100,        1, 32'h0,          32'h0,         0, 0);
        add(1, 1, 32'h180,        1, 1, 32'h0020_0213,  0,   1, 32'h180,        1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h180,        1, 32'h0,          32'h0,         0, 0);
        add(1, 1, 32'h102,        0, 0, 32'h0,          0,   1, 32'h180,        1, 32'h0,          32'h0,         0, 1);
        add(1, 0, 32'h0,          0, 1, 32'h1111_1111,  0,   0, 32'h0,          1, 32'h0,          32'h0,         0, 1);
        add(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0,          32'h0,         0, 1);
        add(1, 1, 32'h200,        0, 0, 32'h0,          0,   1, 32'h200,        1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'h0030_0313,  0,   0, 32'h0,          0, 32'h0030_0313,  32'h200,       0, 0);
        add(1, 1, 32'h40,         0, 0, 32'h0,          0,   1, 32'h40,         1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'hFFFF_FFFF,  1,   0, 32'h0,          0, 32'hFFFF_FFFF,  32'h40,        1, 0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h44,         1, 32'h0,          32'h0,         0, 0);
        add(1, 1, 32'h103,        0, 1, 32'h0,          0,   0, 32'h0,          1, 32'h0,          32'h0,         0, 1);
        add(0, 1, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          1, 32'h0,          32'h0,         0, 0);
        add(1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          0,   1, 32'hFFFF_FFFC,  1, 32'h0,          32'h0,         0, 0);
        add(1, 0, 32'h0,          0, 1, 32'h0040_0413,  0,   0, 32'h0,          0, 32'h0040_0413,  32'hFFFF_FFFC, 0, 0);
        add(1, 0, 32'h0,          1, 0, 32'h0,          0,   1, 32'h0,          1, 32'h0,          32'h0,         0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].jmp, vecs[i].ja, vecs[i].rdy, vecs[i].ack, vecs[i].data, vecs[i].err);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].x_req, vecs[i].x_addr, vecs[i].x_nop,
                          vecs[i].x_instr, vecs[i].x_pc, vecs[i].x_fault, vecs[i].x_mis);
        end

        // Reset while a read is outstanding: request drops without a clock.
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        check("pre_rst.fetchRequest", 32'(mem_if.fetchRequest), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async.fetchRequest", 32'(mem_if.fetchRequest), 32'h0);
        check("rst_async.isNOP", 32'(isNOP), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("rst_done", 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("rst_restart", 1, 32'h0, 1, 32'h0, 32'h0, 0, 0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r_en  = ($urandom_range(0, 7) != 0);
            r_jmp = ($urandom_range(0, 11) == 0);
            r_ja  = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 5) == 0) r_ja[1:0] = 2'($urandom_range(1, 3));
            r_rdy = ($urandom_range(0, 1) == 1);
            r_ack = mem_if.fetchRequest ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            r_d   = $urandom;
            r_err = ($urandom_range(0, 9) == 0);
            drive(r_en, r_jmp, r_ja, r_rdy, r_ack, r_d, r_err);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                @(posedge clk);
                model_step(r_en, r_jmp, r_ja, r_rdy, r_ack, r_d, r_err);
                #1;
            end
            check_outputs("rand", m_busy, m_req_addr, !m_have, m_instr, m_ipc, m_fault, m_halted);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction decoder. It drives the decoder's 32-bit current instruction word and its NOP flag.
- Owns the program counter and issues single-word reads on the core's instruction memory port using a request/acknowledge handshake.
- Holds each fetched word until the downstream stage consumes it.
- Handles jump/branch redirects, including one that arrives while a fetch is in flight.

Parameters:
- RESET_ADDRESS, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  core run enable; no new fetch is issued while low
- jumpEnable  input  1  single-cycle redirect strobe from execute
- jumpAddress  input  32  redirect target
- instructionReady  input  1  downstream consumes the held instruction this cycle
- fetchAddress  output  32  memory read address; word aligned
- fetchRequest  output  1  memory read request; held until acknowledged
- fetchAck  input  1  memory completes the read this cycle
- fetchData  input  32  read data; valid when fetchAck=1
- fetchError  input  1  bus error; qualified by fetchAck
- currentInstruction  output  32  held instruction word to decode
- isNOP  output  1  1 = no valid instruction presented
- programCounter  output  32  address of currentInstruction
- instructionFault  output  1  held word came from an errored fetch
- addressMisaligned  output  1  last redirect target had jumpAddress[1:0] != 0

Behaviour:
- Reset values:
  - state=IDLE; pc=RESET_ADDRESS.
  - fetchRequest=0; isNOP=1.
  - currentInstruction=0; programCounter=RESET_ADDRESS.
  - instructionFault=0; addressMisaligned=0.
- States: IDLE, FETCH, HOLD, FLUSH.
- fetchRequest=1 exactly in FETCH and FLUSH. fetchAddress=pc and stays stable while fetchRequest=1.
- isNOP=0 only in HOLD. currentInstruction, programCounter and instructionFault are registers loaded on the accepted ack.
- IDLE:
  - enable=1 -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - fetchAck=1 -> latch fetchData, fetchError and pc; -> HOLD. The instruction is visible in the cycle after the ack.
  - No ack -> stay in FETCH. enable falling does not abort a fetch in flight.
- HOLD:
  - instructionReady=1 -> pc+=4 (wraps modulo 2^32); -> FETCH if enable, else IDLE.
  - isNOP rises to 1 in the cycle after the consume.
  - No ready -> stay in HOLD with outputs stable.
- Throughput: with a zero-wait memory (ack in the request cycle) and ready always 1, one instruction per 2 cycles.
- Redirect (jumpEnable=1):
  - Has priority over ack and consume in the same cycle.
  - Aligned target: pc<=jumpAddress and addressMisaligned<=0.
  - IDLE or HOLD -> FETCH if enable, else IDLE. Any held instruction is discarded and isNOP=1 next cycle.
  - FETCH with fetchAck=1 in the same cycle: data discarded -> FETCH at the new pc.
  - FETCH with no ack -> FLUSH.
  - FLUSH: on fetchAck, data and error are discarded -> FETCH if enable, else IDLE. A further redirect while in FLUSH updates pc and stays in FLUSH.
- Misaligned target (jumpAddress[1:0] != 0):
  - pc is unchanged and addressMisaligned<=1.
  - Any held instruction is discarded. State goes to IDLE, or to FLUSH if a request is outstanding; FLUSH then -> IDLE on ack.
  - No fetch is issued until the next aligned redirect or a reset.
- Fault: instructionFault=1 is presented with isNOP=0 and is consumed like a normal instruction. Decode/trap logic owns the response.
- Reset mid-transaction drops fetchRequest immediately. The memory port must tolerate an abandoned request.

Decomposition:
- Shared core package:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, FLUSH=2'd3);
  - the RESET_ADDRESS default;
  - the NOP word 32'h0000_0013.
- Single module, no sub-module; the FSM and PC are too small to split.

Test Plan:
- Reset, enable=1, memory acks in the request cycle with data 32'h00500093 at 0x0:
  - fetchAddress=0x0;
  - the cycle after the ack, isNOP=0, currentInstruction=32'h00500093, programCounter=0x0.
- Back-pressure: instructionReady=0 for 5 cycles while in HOLD:
  - outputs stable; fetchRequest=0;
  - on ready=1, the next request goes to 0x4.
- Redirect during a 3-wait-state fetch at 0x8, jumpAddress=0x100:
  - the ack data for 0x8 is never presented;
  - the next fetchAddress is 0x100.
- jumpEnable coincident with fetchAck and instructionReady:
  - redirect wins; isNOP=1 next cycle;
  - next request is to jumpAddress.
- jumpAddress=0x102:
  - addressMisaligned=1; no fetchRequest;
  - a later jump to 0x200 clears the flag and fetches 0x200.
- fetchAck with fetchError=1 at 0x40:
  - instructionFault=1, isNOP=0, programCounter=0x40.
- Assert rst while in FETCH:
  - fetchRequest=0 immediately;
  - after reset is released, the fetch restarts at RESET_ADDRESS.
